// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - opcode, ALUK and instruction field constants for the operand stage
package alu_operand_stage_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    // Shared with the ALU, so keep these encodings in lockstep with it
    localparam logic [1:0] ALUK_ADD = 2'b00;
    localparam logic [1:0] ALUK_AND = 2'b01;
    localparam logic [1:0] ALUK_NOT = 2'b10;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int DR_MSB   = 11;
    localparam int DR_LSB   = 9;
    localparam int SR1_MSB  = 8;
    localparam int SR1_LSB  = 6;
    localparam int IMM_FLAG = 5;
    localparam int IMM_MSB  = 4;
    localparam int IMM_LSB  = 0;
    localparam int SR2_MSB  = 2;
    localparam int SR2_LSB  = 0;

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// rtl/alu_operand_stage_reg_file.sv - 2-read 1-write register file with write-to-read bypass
module reg_file_2r1w #(
    parameter int DATA_SIZE  = 16,
    parameter int REG_NUM    = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    output logic [DATA_SIZE-1:0]  rd_data_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_SIZE-1:0]  rd_data_b,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0]  wr_data
);

    logic [DATA_SIZE-1:0] regs [REG_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Same-cycle writeback is forwarded so the issuing instruction sees the new value
    assign rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
    assign rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - decodes ADD/AND/NOT, reads operands and holds them in one output slot
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_SIZE  = 16,
    parameter int REG_NUM    = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_SIZE-1:0]  OP_A,
    output logic [DATA_SIZE-1:0]  OP_B,
    output logic [1:0]            ALUK,
    output logic [REG_ADDR_W-1:0] out_dr,
    output logic                  illegal,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_SIZE-1:0]  wb_data
);

    logic [3:0]            opcode;
    logic [DATA_SIZE-1:0]  rd_a;
    logic [DATA_SIZE-1:0]  rd_b;
    logic [DATA_SIZE-1:0]  imm_ext;
    logic                  legal;
    logic [1:0]            aluk_d;
    logic [DATA_SIZE-1:0]  op_b_d;
    logic                  accept;
    logic                  transfer;

    assign opcode   = instr[OPC_MSB:OPC_LSB];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;
    assign imm_ext  = {{(DATA_SIZE-5){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};

    reg_file_2r1w #(
        .DATA_SIZE (DATA_SIZE),
        .REG_NUM   (REG_NUM),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr_a(instr[SR1_MSB:SR1_LSB]),
        .rd_data_a(rd_a),
        .rd_addr_b(instr[SR2_MSB:SR2_LSB]),
        .rd_data_b(rd_b),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data)
    );

    always_comb begin
        legal  = 1'b1;
        aluk_d = ALUK_ADD;
        op_b_d = instr[IMM_FLAG] ? imm_ext : rd_b;
        case (opcode)
            OP_ADD: aluk_d = ALUK_ADD;
            OP_AND: aluk_d = ALUK_AND;
            OP_NOT: begin
                aluk_d = ALUK_NOT;
                op_b_d = '0;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal instructions are consumed but never touch the data fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            OP_A      <= '0;
            OP_B      <= '0;
            ALUK      <= ALUK_ADD;
            out_dr    <= '0;
            illegal   <= 1'b0;
        end else begin
            illegal <= accept && !legal;
            if (accept && legal) begin
                out_valid <= 1'b1;
                OP_A      <= rd_a;
                OP_B      <= op_b_d;
                ALUK      <= aluk_d;
                out_dr    <= instr[DR_MSB:DR_LSB];
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed and randomized checks of alu_operand_stage against a reference model
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] OP_A;
    logic [15:0] OP_B;
    logic [1:0]  ALUK;
    logic [2:0]  out_dr;
    logic        illegal;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_regs [8];
    logic        m_valid;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [1:0]  m_k;
    logic [2:0]  m_dr;
    logic        m_ill;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .OP_A     (OP_A),
        .OP_B     (OP_B),
        .ALUK     (ALUK),
        .out_dr   (out_dr),
        .illegal  (illegal),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_valid = 1'b0;
        m_a = 16'h0;
        m_b = 16'h0;
        m_k = 2'd0;
        m_dr = 3'd0;
        m_ill = 1'b0;
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] idx);
        if (wb_en && wb_addr == idx) return wb_data;
        return m_regs[idx];
    endfunction

    task automatic chk_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("op_a", {16'd0, OP_A}, {16'd0, m_a});
        chk("op_b", {16'd0, OP_B}, {16'd0, m_b});
        chk("aluk", {30'd0, ALUK}, {30'd0, m_k});
        chk("out_dr", {29'd0, out_dr}, {29'd0, m_dr});
        chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
    endtask

    // Inputs are already driven; advance one clock and check against the model
    task automatic step();
        logic        exp_ready;
        logic        acc;
        int          op;
        int          imm;
        logic [15:0] a_val;
        logic [15:0] b_val;
        logic [1:0]  k_val;
        logic        is_legal;
        #1;
        exp_ready = !m_valid || out_ready;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        acc = in_valid && exp_ready;
        op = int'(instr[15:12]);
        is_legal = (op == 1) || (op == 5) || (op == 9);
        a_val = m_read(instr[8:6]);
        imm = int'(instr[4:0]);
        if (imm >= 16) imm = imm - 32;
        b_val = instr[5] ? 16'(imm) : m_read(instr[2:0]);
        k_val = (op == 1) ? 2'd0 : (op == 5) ? 2'd1 : 2'd2;
        if (op == 9) b_val = 16'h0;
        @(posedge clk);
        #1;
        m_ill = acc && !is_legal;
        if (acc && is_legal) begin
            m_valid = 1'b1;
            m_a = a_val;
            m_b = b_val;
            m_k = k_val;
            m_dr = instr[11:9];
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (wb_en) m_regs[wb_addr] = wb_data;
        chk_outputs();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        wb_en = 1'b0;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        idle();
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] w);
        in_valid = 1'b1;
        instr = w;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        instr = 16'h0;
        out_ready = 1'b1;
        wb_en = 1'b0;
        wb_addr = 3'd0;
        wb_data = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_outputs();
        rst_n = 1'b1;

        // basic ADD register-register
        write_reg(3'd1, 16'h0005);
        write_reg(3'd2, 16'h0003);
        issue(16'h1642);
        chk("add_rr_a", {16'd0, OP_A}, 32'h5);
        chk("add_rr_b", {16'd0, OP_B}, 32'h3);
        chk("add_rr_dr", {29'd0, out_dr}, 32'd3);

        // immediates and NOT
        issue(16'h187F);
        chk("add_imm_b", {16'd0, OP_B}, 32'hFFFF);
        chk("add_imm_dr", {29'd0, out_dr}, 32'd4);
        issue(16'h506F);
        chk("and_imm_b", {16'd0, OP_B}, 32'h000F);
        chk("and_imm_k", {30'd0, ALUK}, 32'd1);
        issue(16'h9A7F);
        chk("not_a", {16'd0, OP_A}, 32'h5);
        chk("not_b", {16'd0, OP_B}, 32'h0);
        chk("not_k", {30'd0, ALUK}, 32'd2);
        step();

        // backpressure: slot holds, second instr waits, wb does not disturb held operands
        out_ready = 1'b0;
        issue(16'h1642);
        in_valid = 1'b1;
        instr = 16'h1C42;
        wb_en = 1'b1;
        wb_addr = 3'd1;
        wb_data = 16'hAAAA;
        step();
        wb_en = 1'b0;
        chk("hold_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("hold_a", {16'd0, OP_A}, 32'h5);
        chk("hold_dr", {29'd0, out_dr}, 32'd3);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("release_a", {16'd0, OP_A}, 32'hAAAA);
        chk("release_dr", {29'd0, out_dr}, 32'd6);

        // same-cycle writeback bypass, then readback through a NOT
        in_valid = 1'b1;
        instr = 16'h1642;
        wb_en = 1'b1;
        wb_addr = 3'd1;
        wb_data = 16'h1234;
        step();
        wb_en = 1'b0;
        chk("bypass_a", {16'd0, OP_A}, 32'h1234);
        issue(16'h9A7F);
        chk("readback_r1", {16'd0, OP_A}, 32'h1234);

        // illegal opcode while the slot drains
        issue(16'h0000);
        chk("illegal_pulse", {31'd0, illegal}, 32'd1);
        chk("illegal_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("illegal_drop", {31'd0, illegal}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int sel;
            in_valid = 1'($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 4));
            instr = 16'($urandom);
            case (sel)
                0: instr[15:12] = 4'b0001;
                1: instr[15:12] = 4'b0101;
                2: instr[15:12] = 4'b1001;
                3: instr[15:12] = 4'b0001;
                default: ;
            endcase
            out_ready = 1'($urandom_range(0, 2) != 0);
            wb_en = 1'($urandom_range(0, 1));
            wb_addr = 3'($urandom);
            wb_data = 16'($urandom);
            step();
        end
        idle();
        out_ready = 1'b0;

        // async reset with a full output slot
        issue(16'h1642);
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_async_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_async_a", {16'd0, OP_A}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            issue(16'h9000 | 16'(r << 6));
            chk("reset_reg_zero", {16'd0, OP_A}, 32'h0);
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the 3-op ALU (ADD/AND/NOT).
- Accepts 16-bit LC-3-style operate instructions over a valid/ready handshake and decodes them.
- Reads an 8-entry register file, builds OP_A, OP_B and ALUK, and presents them with the destination register from a single registered output slot.
- Also owns the register file write port, which the downstream writeback drives.

Parameters:
- DATA_SIZE, 16, operand and register width.
- REG_NUM, 8, number of general registers.
- REG_ADDR_W, 3, register index width; must satisfy 2**REG_ADDR_W == REG_NUM.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage can accept instr this cycle.
- instr  in  16  instruction word.
- out_valid  out  1  OP_A/OP_B/ALUK/out_dr are valid.
- out_ready  in  1  downstream consumes output this cycle.
- OP_A  out  DATA_SIZE  ALU operand A.
- OP_B  out  DATA_SIZE  ALU operand B.
- ALUK  out  2  ALU function select: 00 ADD, 01 AND, 10 NOT.
- out_dr  out  REG_ADDR_W  destination register carried to writeback.
- illegal  out  1  one-cycle pulse, unsupported opcode dropped.
- wb_en  in  1  register file write enable.
- wb_addr  in  REG_ADDR_W  write index.
- wb_data  in  DATA_SIZE  write data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, OP_A=0, OP_B=0, ALUK=00, out_dr=0, illegal=0; all registers cleared to 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Transfer occurs when out_valid && out_ready.
- Decode on accept, using instr[15:12]:
  - 0001 ADD: ALUK=00.
  - 0101 AND: ALUK=01.
  - 1001 NOT: ALUK=10, OP_B=0.
  - Any other opcode: illegal.
- Field mapping: DR=instr[11:9], SR1=instr[8:6], SR2=instr[2:0].
- For ADD/AND:
  - instr[5]=1: OP_B = sign-extended instr[4:0] to DATA_SIZE.
  - instr[5]=0: OP_B = R[SR2].
- OP_A = R[SR1] for all legal ops.
- NOT ignores instr[5:0].
- Latency: a legal accept in cycle N gives out_valid=1 with captured fields from cycle N+1. Combinational decode and read, one output register.
- Output register update:
  - Legal accept: load decoded fields, out_valid=1.
  - Else if transfer: out_valid=0, data fields hold their last value.
  - Else: hold everything (stable under backpressure).
- Illegal accept: the instruction is consumed, the output register is unchanged, and illegal=1 for exactly the next cycle. If the output slot was full and transferring that cycle, out_valid falls to 0.
- Register file:
  - Writes at the rising edge when wb_en; no write-enable masking.
  - R0 is writable (no hardwired zero).
- Read bypass: if wb_en && wb_addr == the read index in the accept cycle, the read returns wb_data. Applies independently to SR1 and SR2.
- A writeback to a register already captured in a held output does not alter OP_A/OP_B. No scoreboard; hazard ordering is downstream's responsibility.
- Throughput: one instruction per cycle when out_ready stays high.
- Reset mid-operation: a pending output is discarded and registers are cleared; a simultaneous wb is lost.

Decomposition:
- Shared package:
  - opcode constants OP_ADD=4'b0001, OP_AND=4'b0101, OP_NOT=4'b1001.
  - ALUK encodings ALUK_ADD=2'b00, ALUK_AND=2'b01, ALUK_NOT=2'b10, shared with the ALU.
  - field bit positions.
- One natural sub-module: reg_file_2r1w. Two combinational read ports with write bypass, one synchronous write port, async active-low clear.

Test Plan:
- Reset, then wb R1=0x0005 and R2=0x0003; issue ADD R3,R1,R2 (0x1642) with out_ready=1 -> next cycle out_valid=1, OP_A=0x0005, OP_B=0x0003, ALUK=00, out_dr=3.
- R1=0x0005; issue ADD R4,R1,#-1 (0x187F) -> OP_A=0x0005, OP_B=0xFFFF, ALUK=00, out_dr=4; issue AND R0,R1,#15 (0x506F) -> OP_B=0x000F, ALUK=01, out_dr=0.
- R1=0x0005; issue NOT R5,R1 (0x9A7F) -> OP_A=0x0005, OP_B=0x0000, ALUK=10, out_dr=5.
- Hold out_ready=0 with an ADD pending; present a second instr and wb R1=0xAAAA -> in_ready=0; outputs unchanged for 5 cycles; after out_ready=1, the second instr issues the following cycle.
- In the accept cycle of ADD R3,R1,R2, drive wb_en=1, wb_addr=1, wb_data=0x1234 -> OP_A=0x1234 (bypass); R1 reads 0x1234 afterwards.
- Issue opcode 0x0 instr (0x0000) -> illegal pulses 1 cycle, out_valid stays 0; assert rst_n=0 while out_valid=1 -> out_valid=0 immediately and all registers read 0.
